// File: rtl/shift_pkg.sv
// Shared mode encodings, FSM state type and burst-mode classifier for the
// universal shift register and its next-value function.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Only the shift and rotate modes may be repeated by the burst engine.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_op.sv
// Combinational next-value function: one operation of the selected mode
// applied to the current register contents.
module shift_op
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_in_r_i,
  input  logic             ser_in_l_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic [WIDTH-1:0] next_q_o
);

  always_comb begin
    next_q_o = q_i;
    case (mode_i)
      MODE_HOLD: next_q_o = q_i;
      MODE_SHL:  next_q_o = {q_i[WIDTH-2:0], ser_in_r_i};
      MODE_SHR:  next_q_o = {ser_in_l_i, q_i[WIDTH-1:1]};
      MODE_LOAD: next_q_o = load_data_i;
      MODE_ROL:  next_q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:  next_q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ASR:  next_q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_CLR:  next_q_o = '0;
      default:   next_q_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit register with per-cycle mode select, clock enable and a burst
// engine that repeats a latched shift/rotate for burst_len enabled cycles.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               LEN_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             Rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic             burst_start,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bmode_q, bmode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] op_next;

  // While bursting, the live mode input is ignored in favour of the latched one.
  assign op_mode = (state_q == S_BURST) ? bmode_q : mode;

  shift_op #(.WIDTH(WIDTH)) u_op (
    .q_i        (q_q),
    .mode_i     (op_mode),
    .ser_in_r_i (ser_in_r),
    .ser_in_l_i (ser_in_l),
    .load_data_i(load_data),
    .next_q_o   (op_next)
  );

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bmode_d = bmode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (burst_start && is_burst_mode(mode)) begin
            bmode_d = mode;
            cnt_d   = burst_len;
            if (burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_BURST;
              busy_d  = 1'b1;
            end
          end else begin
            q_d = op_next;
          end
        end
        S_BURST: begin
          q_d   = op_next;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (Rst) begin
      q_q     <= RST_VAL;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bmode_q <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q         = q_q;
  assign ser_out_l = q_q[WIDTH-1];
  assign ser_out_r = q_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: each driven cycle pushes the expected
// {Q, ser_out_l, ser_out_r, busy, done}; a monitor pops and compares at negedge.
module tb_univ_shift_reg;
  import shift_pkg::*;

  localparam int EW = 12;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       Rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] load_data = '0;
  logic       ser_in_r = 1'b0;
  logic       ser_in_l = 1'b0;
  logic       burst_start = 1'b0;
  logic [3:0] burst_len = '0;
  logic [7:0] Q;
  logic       ser_out_l, ser_out_r, busy, done;
  state_t     dbg_state;

  univ_shift_reg #(.WIDTH(8), .LEN_W(4), .RST_VAL(8'h00)) dut (
    .clock      (clock),
    .Rst        (Rst),
    .en         (en),
    .mode       (mode),
    .load_data  (load_data),
    .ser_in_r   (ser_in_r),
    .ser_in_l   (ser_in_l),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .Q          (Q),
    .ser_out_l  (ser_out_l),
    .ser_out_r  (ser_out_r),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // driver: apply inputs for one edge, then record what must be visible after it
  task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                     input logic [7:0] ld, input logic sr, input logic sl,
                     input logic bs, input logic [3:0] bl,
                     input logic [7:0] eq, input logic eb, input logic ed);
    Rst = r; en = e; mode = m; load_data = ld;
    ser_in_r = sr; ser_in_l = sl; burst_start = bs; burst_len = bl;
    @(posedge clock);
    exp_q.push_back({eq, eq[7], eq[0], eb, ed});
    #1;
  endtask

  // monitor
  initial begin
    logic [EW-1:0] exp_v, act_v;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {Q, ser_out_l, ser_out_r, busy, done};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_check_%0d: got Q=%h sol=%b sor=%b busy=%b done=%b, expected Q=%h sol=%b sor=%b busy=%b done=%b",
                   checks, act_v[11:4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    // reset, then reset-between-edges has no effect, then a real reset pulse
    cyc(1, 0, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc(0, 1, MODE_LOAD, 8'hFF, 0, 0, 0, 4'd0, 8'hFF, 0, 0);
    Rst = 1'b1; #3; Rst = 1'b0;
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'hFF, 0, 0);
    cyc(1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);

    // per-mode operations
    cyc(0, 1, MODE_LOAD, 8'hB4, 0, 0, 0, 4'd0, 8'hB4, 0, 0);
    cyc(0, 1, MODE_SHL,  8'h00, 1, 0, 0, 4'd0, 8'h69, 0, 0);
    cyc(0, 1, MODE_SHR,  8'h00, 0, 0, 0, 4'd0, 8'h34, 0, 0);
    cyc(0, 1, MODE_ROR,  8'h00, 0, 0, 0, 4'd0, 8'h1A, 0, 0);
    cyc(0, 0, MODE_LOAD, 8'h55, 0, 0, 0, 4'd0, 8'h1A, 0, 0);
    cyc(0, 1, MODE_LOAD, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    cyc(0, 1, MODE_ROL,  8'h00, 0, 0, 0, 4'd0, 8'h03, 0, 0);
    cyc(0, 1, MODE_LOAD, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    cyc(0, 1, MODE_ASR,  8'h00, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
    cyc(0, 1, MODE_CLR,  8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc(0, 1, MODE_SHR,  8'h00, 0, 1, 0, 4'd0, 8'h80, 0, 0);
    // burst_start with a non-shift mode is just a single op
    cyc(0, 1, MODE_LOAD, 8'h5A, 0, 0, 1, 4'd3, 8'h5A, 0, 0);

    // ROL burst of 3 with mode/load_data/burst_start changing while busy
    cyc(0, 1, MODE_LOAD, 8'h01, 0, 0, 0, 4'd0, 8'h01, 0, 0);
    cyc(0, 1, MODE_ROL,  8'h00, 0, 0, 1, 4'd3, 8'h01, 1, 0);
    cyc(0, 1, MODE_LOAD, 8'hFF, 0, 0, 1, 4'd7, 8'h02, 1, 0);
    cyc(0, 1, MODE_CLR,  8'hFF, 0, 0, 0, 4'd0, 8'h04, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 1);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0);

    // SHL burst of 4 with a 2-cycle stall; done clears even with en=0
    cyc(0, 1, MODE_LOAD, 8'h01, 0, 0, 0, 4'd0, 8'h01, 0, 0);
    cyc(0, 1, MODE_SHL,  8'h00, 0, 0, 1, 4'd4, 8'h01, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h02, 1, 0);
    cyc(0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h02, 1, 0);
    cyc(0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h02, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h04, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h08, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h10, 0, 1);
    cyc(0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h10, 0, 0);

    // zero-length burst: no shift, no busy, done next cycle
    cyc(0, 1, MODE_SHL,  8'h00, 1, 0, 1, 4'd0, 8'h10, 0, 1);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h10, 0, 0);

    // reset mid-burst aborts without done
    cyc(0, 1, MODE_LOAD, 8'h80, 0, 0, 0, 4'd0, 8'h80, 0, 0);
    cyc(0, 1, MODE_ROR,  8'h00, 0, 0, 1, 4'd5, 8'h80, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h40, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h20, 1, 0);
    cyc(1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);

    // back-to-back: second burst requested in the done cycle
    cyc(0, 1, MODE_LOAD, 8'h01, 0, 0, 0, 4'd0, 8'h01, 0, 0);
    cyc(0, 1, MODE_ROL,  8'h00, 0, 0, 1, 4'd2, 8'h01, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h02, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h04, 0, 1);
    cyc(0, 1, MODE_SHR,  8'h00, 0, 1, 1, 4'd2, 8'h04, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 1, 0, 4'd0, 8'h82, 1, 0);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h41, 0, 1);
    cyc(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 4'd0, 8'h41, 0, 0);

    // drain: the monitor pops each entry half a cycle after it is pushed
    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with per-cycle mode select and clock-enable.
- Modes: hold, logical and arithmetic shifts, rotates, parallel load and clear.
- A burst engine runs a selected shift/rotate for N consecutive enabled cycles, then pulses done.
- Used as the generic storage/serialiser element in datapath labs and test fixtures.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- LEN_W, 4, width of burst_len; burst length range is 0..2^LEN_W-1.
- RST_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- clock  input  1  single clock; all state changes on posedge.
- Rst  input  1  reset, synchronous, active-high.
- en  input  1  clock enable; 0 freezes Q and the burst engine.
- mode  input  3  operation select, decoded below.
- load_data  input  WIDTH  parallel load value.
- ser_in_r  input  1  bit entering LSB on shift-left.
- ser_in_l  input  1  bit entering MSB on logical shift-right.
- burst_start  input  1  request a burst of the current mode.
- burst_len  input  LEN_W  number of burst operations.
- Q  output  WIDTH  register contents (registered).
- ser_out_l  output  1  Q[WIDTH-1], combinational from Q.
- ser_out_r  output  1  Q[0], combinational from Q.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (Rst=1 at posedge):
  - Q<=RST_VAL, busy<=0, done<=0, burst counter<=0, state IDLE.
  - Reset overrides en, mode and burst_start, including mid-burst; the aborted burst produces no done.
- Mode decode, applied at posedge when en=1:
  - 000 HOLD: Q unchanged.
  - 001 SHL: Q<={Q[WIDTH-2:0],ser_in_r}.
  - 010 SHR: Q<={ser_in_l,Q[WIDTH-1:1]}.
  - 011 LOAD: Q<=load_data.
  - 100 ROL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 101 ROR: Q<={Q[0],Q[WIDTH-1:1]}.
  - 110 ASR: Q<={Q[WIDTH-1],Q[WIDTH-1:1]}.
  - 111 CLR: Q<=0.
- en=0: Q, state and counter all hold; done is still cleared to 0 (done is never stretched).
- Latency: one cycle; the new Q is visible after the posedge that samples the inputs.
- FSM states IDLE and BURST.
- IDLE:
  - Per-cycle mode ops apply as above.
  - If en=1, burst_start=1 and mode is a shift/rotate (001,010,100,101,110): latch mode into burst_mode and burst_len into cnt. No shift occurs on this edge.
    - If burst_len=0: stay IDLE and assert done next cycle.
    - Else: go to BURST with busy=1.
  - burst_start with mode 000/011/111: executed as a normal single-cycle op; no burst, no done.
- BURST:
  - Each en=1 edge applies burst_mode to Q and decrements cnt.
  - On the edge where cnt goes 1->0: return to IDLE, busy<=0, done<=1 for exactly one cycle.
  - mode, load_data and burst_start are ignored while busy; serial inputs are still sampled for SHL/SHR.
  - en=0 stalls the burst with no count loss.
- Back-to-back bursts: burst_start is accepted in the same cycle done is high, because the state is already IDLE.
- Width rules: shifts are exactly one position per operation; no arithmetic overflow exists; cnt is LEN_W bits and never underflows.

Decomposition:
- Shared package shift_pkg holds:
  - Mode encoding constants: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR.
  - FSM state constants S_IDLE, S_BURST.
- Sub-module shift_op: purely combinational next-value function taking (Q, mode, ser_in_r, ser_in_l, load_data) and producing next_Q.
  - Instantiated once, fed either mode or burst_mode.
- The top level holds Q, the FSM and the counter.

Test Plan (WIDTH=8, LEN_W=4, RST_VAL=0):
- Reset: Q=8'hFF held, pulse Rst for one edge -> Q=8'h00, busy=0, done=0 next cycle; Rst asserted between edges has no effect until the next posedge.
- Per-mode check: LOAD 8'hB4, then SHL ser_in_r=1 -> 8'h69; then SHR ser_in_l=0 -> 8'h34; then ROR -> 8'h1A.
  - Separately, LOAD 8'h81: ROL -> 8'h03; ASR from 8'h81 -> 8'hC0; CLR -> 8'h00.
- Burst: Q=8'h01, mode=ROL, burst_start, burst_len=3 -> busy high for 3 cycles; Q sequence 02,04,08; done pulses once as busy falls; mode changes during busy are ignored.
- Stall and zero length:
  - Burst SHL len=4 on 8'h01 with ser_in_r=0 and en=0 for 2 cycles mid-burst -> final Q=8'h10, and done arrives 2 cycles late.
  - burst_len=0 -> Q unchanged, busy never high, done pulses the next cycle.
- Reset mid-burst: ROR len=5, assert Rst after 2 shifts -> Q=8'h00, busy=0, no done pulse.
- Back-to-back: start a second burst in the done cycle -> accepted, busy reasserts, and the counts of both bursts are honoured.
